// File: rtl/axil_slave_fsm.sv
// axil_slave_fsm: AXI4-Lite slave engine for the VGA controller register port.
// Turns AXI-Lite write/read transactions into single-cycle native strobes.
// The write and read channels are independent FSMs. The AXI-Lite channel
// signals of vga_axil_if appear here as flat ports.
// Optional feature macro: VGA_AXIL_SLVERR_EN. When defined, a misaligned
// address produces no native strobe and returns SLVERR.

package vga_axil_pkg;
  localparam int AXIL_ADDR_WIDTH   = 32;
  localparam int AXIL_DATA_WIDTH   = 32;
  localparam int AXIL_WIDTH_OFFSET = $clog2(AXIL_DATA_WIDTH / 8);
  typedef logic [AXIL_ADDR_WIDTH-AXIL_WIDTH_OFFSET-1:0] native_addr_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

module axil_slave_fsm
  import vga_axil_pkg::*;
(
  input  logic                       clk_if,
  input  logic                       arst_n,
  // AW channel
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [AXIL_ADDR_WIDTH-1:0] awaddr,
  // W channel
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [AXIL_DATA_WIDTH-1:0] wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
  // B channel
  output logic                       bvalid,
  input  logic                       bready,
  output logic [1:0]                 bresp,
  // AR channel
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [AXIL_ADDR_WIDTH-1:0] araddr,
  // R channel
  output logic                       rvalid,
  input  logic                       rready,
  output logic [AXIL_DATA_WIDTH-1:0] rdata,
  output logic [1:0]                 rresp,
  // Native register/memory port
  input  logic [AXIL_DATA_WIDTH-1:0] data_i,
  output native_addr_t               addr_write_o,
  output native_addr_t               addr_read_o,
  output logic [AXIL_DATA_WIDTH-1:0] data_o,
  output logic                       read_en_sync_o,
  output logic                       write_en_o
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_WRITE = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_READ  = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_RESP  = 2'd3;

  logic [1:0] w_state;
  logic [1:0] r_state;
  logic       aw_held;
  logic       w_held;
  logic       ar_held;
  logic       aw_err;
  logic       ar_err;

  logic       aw_hs;
  logic       w_hs;
  logic       ar_hs;
  logic       aw_misaligned;
  logic       ar_misaligned;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

`ifdef VGA_AXIL_SLVERR_EN
  assign aw_misaligned = |awaddr[AXIL_WIDTH_OFFSET-1:0];
  assign ar_misaligned = |araddr[AXIL_WIDTH_OFFSET-1:0];
`else
  assign aw_misaligned = 1'b0;
  assign ar_misaligned = 1'b0;
`endif

  // Byte strobes and the byte offset are intentionally not used by the datapath.
  logic unused_ok;
  assign unused_ok = ^{wstrb, awaddr[AXIL_WIDTH_OFFSET-1:0], araddr[AXIL_WIDTH_OFFSET-1:0]};

  // Native strobes are decoded from the registered state, so each lasts one cycle.
  assign write_en_o     = (w_state == W_WRITE) && !aw_err;
  assign read_en_sync_o = (r_state == R_READ) && !ar_err;

  // Write channel FSM: collect AW and W in any order, strobe once, then respond.
  always_ff @(posedge clk_if or negedge arst_n) begin
    if (!arst_n) begin
      w_state      <= W_IDLE;
      awready      <= 1'b0;
      wready       <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_err       <= 1'b0;
      addr_write_o <= '0;
      data_o       <= '0;
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // sees the pre-edge values regardless of statement order.
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            w_state <= W_WRITE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_held      <= 1'b1;
              aw_err       <= aw_misaligned;
              addr_write_o <= awaddr[AXIL_ADDR_WIDTH-1:AXIL_WIDTH_OFFSET];
            end
            if (w_hs) begin
              w_held <= 1'b1;
              data_o <= wdata;
            end
            // A channel stops accepting once its beat has been captured.
            awready <= !(aw_held || aw_hs);
            wready  <= !(w_held || w_hs);
          end
        end
        W_WRITE: begin
          w_state <= W_RESP;
          bvalid  <= 1'b1;
          bresp   <= aw_err ? RESP_SLVERR : RESP_OKAY;
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        // NOTE: the default arm recovers from the unused encoding and keeps
        // the case fully specified.
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: capture AR, strobe the synchronous read, register data, respond.
  always_ff @(posedge clk_if or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= R_IDLE;
      arready     <= 1'b0;
      ar_held     <= 1'b0;
      ar_err      <= 1'b0;
      addr_read_o <= '0;
      rvalid      <= 1'b0;
      rdata       <= '0;
      rresp       <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_held) begin
            r_state <= R_READ;
            ar_held <= 1'b0;
          end else begin
            if (ar_hs) begin
              ar_held     <= 1'b1;
              ar_err      <= ar_misaligned;
              addr_read_o <= araddr[AXIL_ADDR_WIDTH-1:AXIL_WIDTH_OFFSET];
            end
            arready <= !ar_hs;
          end
        end
        R_READ: begin
          r_state <= R_WAIT;
        end
        R_WAIT: begin
          // The native memory presents data_i one cycle after the strobe.
          r_state <= R_RESP;
          rvalid  <= 1'b1;
          rdata   <= ar_err ? '0 : data_i;
          rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
            arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_slave_fsm.sv
// tb_axil_slave_fsm: directed self-checking bench for axil_slave_fsm with a
// small synchronous-read native memory model. Covers VGA_AXIL_SLVERR_EN
// behaviour when that macro is defined.
`timescale 1ns/1ps

module tb_axil_slave_fsm;

  logic        clk_if;
  logic        arst_n;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [31:0] data_i;
  logic [29:0] addr_write_o;
  logic [29:0] addr_read_o;
  logic [31:0] data_o;
  logic        read_en_sync_o;
  logic        write_en_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [0:63];
  logic [31:0] exp_mem [0:63];
  int          wa_q [$];
  logic [31:0] wd_q [$];
  int          ra_q [$];

  axil_slave_fsm dut (
    .clk_if         (clk_if),
    .arst_n         (arst_n),
    .awvalid        (awvalid),
    .awready        (awready),
    .awaddr         (awaddr),
    .wvalid         (wvalid),
    .wready         (wready),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .bvalid         (bvalid),
    .bready         (bready),
    .bresp          (bresp),
    .arvalid        (arvalid),
    .arready        (arready),
    .araddr         (araddr),
    .rvalid         (rvalid),
    .rready         (rready),
    .rdata          (rdata),
    .rresp          (rresp),
    .data_i         (data_i),
    .addr_write_o   (addr_write_o),
    .addr_read_o    (addr_read_o),
    .data_o         (data_o),
    .read_en_sync_o (read_en_sync_o),
    .write_en_o     (write_en_o)
  );

  initial clk_if = 1'b0;
  always #5 clk_if = ~clk_if;

  // Native side: synchronous-read memory plus a log of every strobe.
  always @(posedge clk_if) begin
    if (write_en_o) begin
      mem[addr_write_o[5:0]] <= data_o;
      wa_q.push_back(int'(addr_write_o));
      wd_q.push_back(data_o);
    end
    if (read_en_sync_o) begin
      data_i <= mem[addr_read_o[5:0]];
      ra_q.push_back(int'(addr_read_o));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic [1:0] resp);
    bit aw_done, w_done, b_done, hs_aw, hs_w;
    aw_done = 0; w_done = 0; b_done = 0; resp = 2'b11;
    awaddr = addr; wdata = data; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_w_accepted", {aw_done, w_done}, 2'b11);
    bready = 1'b1;
    for (int c = 0; c < 50 && !b_done; c++) begin
      if (bvalid) begin resp = bresp; b_done = 1; end
      tick();
    end
    bready = 1'b0;
    check("b_received", b_done, 1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done, r_done, hs;
    ar_done = 0; r_done = 0; data = '0; resp = 2'b11;
    araddr = addr; arvalid = 1'b1;
    for (int c = 0; c < 50 && !ar_done; c++) begin
      hs = arvalid && arready;
      tick();
      if (hs) begin arvalid = 1'b0; ar_done = 1; end
    end
    arvalid = 1'b0;
    check("ar_accepted", ar_done, 1);
    rready = 1'b1;
    for (int c = 0; c < 50 && !r_done; c++) begin
      if (rvalid) begin data = rdata; resp = rresp; r_done = 1; end
      tick();
    end
    rready = 1'b0;
    check("r_received", r_done, 1);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [31:0] v;

    arst_n = 1'b0;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    arvalid = 0; araddr = '0; rready = 0;

    // Reset values
    repeat (2) @(posedge clk_if);
    #1;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_write_en", write_en_o, 0);
    check("rst_read_en", read_en_sync_o, 0);
    check("rst_addr_write", addr_write_o, 0);
    check("rst_addr_read", addr_read_o, 0);
    check("rst_data_o", data_o, 0);
    @(negedge clk_if);
    arst_n = 1'b1;
    tick();
    check("post_rst_awready", awready, 1);
    check("post_rst_wready", wready, 1);
    check("post_rst_arready", arready, 1);

    // Sequential writes, data = address
    for (int i = 0; i < 10; i++) begin
      axi_write(i * 4, i * 4, resp);
      exp_mem[i] = i * 4;
      check("seq_wr_bresp", resp, 2'b00);
      check("seq_wr_strobes", wa_q.size(), 1);
      if (wa_q.size() > 0) begin
        check("seq_wr_addr", wa_q.pop_front(), i);
        check("seq_wr_data", wd_q.pop_front(), i * 4);
      end
    end

    // Sequential readback
    for (int i = 0; i < 10; i++) begin
      axi_read(i * 4, d, resp);
      check("seq_rd_data", d, i * 4);
      check("seq_rd_rresp", resp, 2'b00);
      check("seq_rd_strobes", ra_q.size(), 1);
      if (ra_q.size() > 0) check("seq_rd_addr", ra_q.pop_front(), i);
    end

    // Concurrent channels: writes to words 10..19 while reading words 0..9
    fork
      begin
        logic [1:0]  wr_resp;
        logic [31:0] wv;
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 10)) tick();
          wv = $urandom;
          exp_mem[10 + i] = wv;
          axi_write((10 + i) * 4, wv, wr_resp);
          check("conc_wr_bresp", wr_resp, 2'b00);
        end
      end
      begin
        logic [1:0]  rd_resp;
        logic [31:0] rv;
        int          a;
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 10)) tick();
          a = $urandom_range(0, 9);
          axi_read(a * 4, rv, rd_resp);
          check("conc_rd_data", rv, exp_mem[a]);
          check("conc_rd_rresp", rd_resp, 2'b00);
        end
      end
    join
    for (int i = 10; i < 20; i++) begin
      axi_read(i * 4, d, resp);
      check("conc_readback", d, exp_mem[i]);
    end
    wa_q.delete(); wd_q.delete(); ra_q.delete();

    // Channel ordering: W three cycles before AW
    v = 32'hA5A5_0014;
    wdata = v; wstrb = 4'hF;
    check("ord_wready_idle", wready, 1);
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("ord_wready_after_w", wready, 0);
    check("ord_awready_waiting", awready, 1);
    tick();
    tick();
    awaddr = 32'h50;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("ord_no_early_strobe", write_en_o, 0);
    check("ord_awready_after_aw", awready, 0);
    tick();
    check("ord_write_en", write_en_o, 1);
    check("ord_addr_write", addr_write_o, 20);
    check("ord_data_o", data_o, v);
    tick();
    check("ord_write_en_once", write_en_o, 0);
    check("ord_bvalid", bvalid, 1);
    check("ord_bresp", bresp, 2'b00);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("ord_bvalid_clear", bvalid, 0);
    check("ord_awready_back", awready, 1);
    check("ord_strobe_count", wa_q.size(), 1);
    exp_mem[20] = v;
    wa_q.delete(); wd_q.delete();

    // Channel ordering: AW and W in the same cycle
    axi_write(32'h54, 32'h5A5A_0015, resp);
    exp_mem[21] = 32'h5A5A_0015;
    check("same_bresp", resp, 2'b00);
    check("same_strobe_count", wa_q.size(), 1);
    if (wa_q.size() > 0) check("same_addr", wa_q.pop_front(), 21);
    wa_q.delete(); wd_q.delete();

    // Write backpressure
    v = 32'h0BAD_CAFE;
    awaddr = 32'h58; wdata = v;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_w_ready_low", {awready, wready}, 2'b00);
    tick();
    check("bp_w_strobe", write_en_o, 1);
    tick();
    check("bp_bvalid_rise", bvalid, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_bvalid_hold", bvalid, 1);
      check("bp_bresp_hold", bresp, 2'b00);
      check("bp_awready_low", awready, 0);
      check("bp_wready_low", wready, 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bp_bvalid_clear", bvalid, 0);
    check("bp_awready_back", awready, 1);
    exp_mem[22] = v;

    // Read latency and backpressure
    araddr = 32'h58;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("bp_arready_low", arready, 0);
    check("bp_no_early_read", read_en_sync_o, 0);
    tick();
    check("bp_read_en", read_en_sync_o, 1);
    check("bp_addr_read", addr_read_o, 22);
    tick();
    check("bp_read_en_once", read_en_sync_o, 0);
    check("bp_rvalid_not_yet", rvalid, 0);
    tick();
    check("bp_rvalid_rise", rvalid, 1);
    check("bp_rdata", rdata, exp_mem[22]);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_rvalid_hold", rvalid, 1);
      check("bp_rdata_hold", rdata, exp_mem[22]);
      check("bp_rresp_hold", rresp, 2'b00);
      check("bp_arready_hold", arready, 0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("bp_rvalid_clear", rvalid, 0);
    check("bp_arready_back", arready, 1);
    wa_q.delete(); wd_q.delete(); ra_q.delete();

    // Reset between the AW/W handshake and the write strobe
    awaddr = 32'h5C; wdata = 32'hDEAD_BEEF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    arst_n = 1'b0;
    #1;
    check("mid_rst_write_en", write_en_o, 0);
    check("mid_rst_addr_write", addr_write_o, 0);
    check("mid_rst_data_o", data_o, 0);
    check("mid_rst_readies", {awready, wready, arready}, 3'b000);
    check("mid_rst_bvalid", bvalid, 0);
    @(negedge clk_if);
    arst_n = 1'b1;
    repeat (5) tick();
    check("mid_rst_no_strobe", wa_q.size(), 0);
    check("mid_rst_no_bvalid", bvalid, 0);
    check("mid_rst_awready", awready, 1);
    axi_read(32'h50, d, resp);
    check("mid_rst_recover_rd", d, exp_mem[20]);
    wa_q.delete(); wd_q.delete(); ra_q.delete();

    // Misaligned address
`ifdef VGA_AXIL_SLVERR_EN
    axi_write(32'h6, 32'h66, resp);
    check("slverr_bresp", resp, 2'b10);
    check("slverr_no_write", wa_q.size(), 0);
    axi_read(32'h6, d, resp);
    check("slverr_rresp", resp, 2'b10);
    check("slverr_rdata", d, 0);
    check("slverr_no_read", ra_q.size(), 0);
`else
    axi_write(32'h6, 32'h66, resp);
    check("unaligned_bresp", resp, 2'b00);
    check("unaligned_strobe", wa_q.size(), 1);
    if (wa_q.size() > 0) check("unaligned_addr", wa_q.pop_front(), 1);
    axi_read(32'h4, d, resp);
    check("unaligned_readback", d, 32'h66);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
